// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared types and encodings for the multicycle RV32 controller.
// Revision    : 1.0
// ============================================================================
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_rtype = 7'b0110011;
    localparam logic [6:0] c_op_itype = 7'b0010011;
    localparam logic [6:0] c_op_jal   = 7'b1101111;
    localparam logic [6:0] c_op_beq   = 7'b1100011;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_slt = 3'b101;

    localparam logic [1:0] c_imm_i = 2'b00;
    localparam logic [1:0] c_imm_s = 2'b01;
    localparam logic [1:0] c_imm_b = 2'b10;
    localparam logic [1:0] c_imm_j = 2'b11;

    localparam logic [1:0] c_res_aluout    = 2'b00;
    localparam logic [1:0] c_res_data      = 2'b01;
    localparam logic [1:0] c_res_aluresult = 2'b10;

    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rd1   = 2'b10;

    localparam logic [1:0] c_srcb_rd2  = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            c_op_store: imm_src = c_imm_s;
            c_op_beq:   imm_src = c_imm_b;
            c_op_jal:   imm_src = c_imm_j;
            default:    imm_src = c_imm_i;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_if
// Description : Instruction fields and status in, datapath controls out.
// Revision    : 1.0
// ============================================================================
interface multicycle_controller_if;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic        RegWrite;
    logic        Halted;
    logic [31:0] InstRet;

    modport master (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, Halted, InstRet
    );

    modport slave (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, Halted, InstRet
    );
endinterface
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps ALUOp and instruction function fields to ALUControl.
// Revision    : 1.0
// ============================================================================
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_t     i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alucontrol
);
    always_comb begin
        o_alucontrol = c_alu_add;
        case (i_aluop)
            ALUOP_SUB: o_alucontrol = c_alu_sub;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type with bit 30 set is a subtract; addi never is.
                    3'b000:  o_alucontrol = ({i_op5, i_funct7b5} == 2'b11) ? c_alu_sub : c_alu_add;
                    3'b010:  o_alucontrol = c_alu_slt;
                    3'b110:  o_alucontrol = c_alu_or;
                    3'b111:  o_alucontrol = c_alu_and;
                    default: o_alucontrol = c_alu_add;
                endcase
            end
            default: o_alucontrol = c_alu_add;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle RV32 control FSM with halt flag and retire counter.
// Revision    : 1.0
// ============================================================================
module multicycle_controller #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RST,
    multicycle_controller_if.slave bus
);
    import riscv_ctrl_pkg::*;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instret;
    logic        r_halted;
    aluop_t      w_aluop;
    logic        w_ready;
    logic        w_retire;
    logic        w_pcwrite;
    logic        w_irwrite;
    logic        w_memwrite;
    logic        w_regwrite;
    logic        w_adrsrc;
    logic [1:0]  w_resultsrc;
    logic [1:0]  w_alusrca;
    logic [1:0]  w_alusrcb;
    logic [2:0]  w_alucontrol;

    generate
        if (MEM_WAIT_EN) begin : g_mem_wait
            assign w_ready = bus.MemReady;
        end else begin : g_no_mem_wait
            assign w_ready = 1'b1;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_FETCH;
            r_halted  <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_next == S_HALT) begin
                r_halted <= 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pcwrite   = 1'b0;
        w_irwrite   = 1'b0;
        w_memwrite  = 1'b0;
        w_regwrite  = 1'b0;
        w_adrsrc    = 1'b0;
        w_resultsrc = c_res_aluout;
        w_alusrca   = c_srca_pc;
        w_alusrcb   = c_srcb_rd2;
        w_aluop     = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_resultsrc = c_res_aluresult;
                w_alusrcb   = c_srcb_four;
                w_irwrite   = w_ready;
                w_pcwrite   = w_ready;
                if (w_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_alusrca = c_srca_oldpc;
                w_alusrcb = c_srcb_imm;
                case (bus.op)
                    c_op_load, c_op_store: w_next = S_MEMADR;
                    c_op_rtype:            w_next = S_EXECR;
                    c_op_itype:            w_next = S_EXECI;
                    c_op_jal:              w_next = S_JAL;
                    c_op_beq:              w_next = S_BEQ;
                    default:               w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                w_alusrca = c_srca_rd1;
                w_alusrcb = c_srcb_imm;
                w_next    = (bus.op == c_op_load) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                if (w_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultsrc = c_res_data;
                w_regwrite  = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
                if (w_ready) w_next = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                w_alusrca = c_srca_rd1;
                w_alusrcb = (r_state == S_EXECI) ? c_srcb_imm : c_srcb_rd2;
                w_aluop   = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                w_alusrca = c_srca_oldpc;
                w_alusrcb = c_srcb_four;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_BEQ: begin
                w_alusrca = c_srca_rd1;
                w_alusrcb = c_srcb_rd2;
                w_aluop   = ALUOP_SUB;
                w_pcwrite = bus.Zero;
                w_next    = S_FETCH;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    assign w_retire = (w_next == S_FETCH) &&
                      ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                       (r_state == S_ALUWB) || (r_state == S_BEQ));

    alu_decoder u_alu_decoder (
        .i_aluop      (w_aluop),
        .i_funct3     (bus.funct3),
        .i_funct7b5   (bus.funct7b5),
        .i_op5        (bus.op[5]),
        .o_alucontrol (w_alucontrol)
    );

    // Write enables are gated by reset so an aborted access never commits.
    assign bus.PCWrite    = w_pcwrite  & ~RST;
    assign bus.IRWrite    = w_irwrite  & ~RST;
    assign bus.MemWrite   = w_memwrite & ~RST;
    assign bus.RegWrite   = w_regwrite & ~RST;
    assign bus.AdrSrc     = w_adrsrc;
    assign bus.ResultSrc  = w_resultsrc;
    assign bus.ALUSrcA    = w_alusrca;
    assign bus.ALUSrcB    = w_alusrcb;
    assign bus.ALUControl = w_alucontrol;
    assign bus.ImmSrc     = imm_src(bus.op);
    assign bus.Halted     = r_halted;
    assign bus.InstRet    = r_instret;
endmodule
`default_nettype wire
